clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Multi-channel tick scheduler that owns a shared free-running 32-bit divider counter and arbitrates its taps among NUM_CH requesters. Each channel is configured at run time to a tap bit and a periodic or one-shot mode, and emits one-cycle tick enables on rising edges of that tap. Sits between the board clock and the slow consumers (display scan, debouncers, blinkers), replacing ad-hoc per-module dividers.

## Interface
- NUM_CH, 4: number of tick channels (1..8).
- CNT_W, 32: shared counter width; taps are 0..CNT_W-1.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  block can accept a write this cycle.
- cfg_ch  input  3  target channel index.
- cfg_tap  input  5  counter bit to follow.
- cfg_mode  input  1  0 = periodic, 1 = one-shot.
- cfg_en  input  1  1 = arm channel, 0 = stop channel.
- cfg_err  output  1  one-cycle pulse: accepted write had cfg_ch >= NUM_CH.
- tick  output  NUM_CH  per-channel one-cycle tick enable.
- done  output  NUM_CH  per-channel one-shot completed flag.
- cnt  output  CNT_W  current shared counter value.

## Operation
- Shared counter: increments by 1 every cycle and wraps from 2^CNT_W-1 to 0. No reset other than rst.
- Tap edge for channel i: cnt[tap_i] = 1 and the registered previous value of that bit = 0. Tap k rises every 2^(k+1) cycles.
- Handshake: a write is accepted when cfg_valid && cfg_ready. cfg_ready = 0 for exactly the cycle after an accept, and 1 otherwise. Held cfg_valid therefore yields one accept every 2 cycles.
- A write with cfg_ch >= NUM_CH is accepted with no state change and pulses cfg_err.
- Per-channel FSM:
  - IDLE: tick = 0. A write with en = 1 latches tap and mode, clears done, and moves to ARM.
  - ARM: discards the partial period. The first tap edge moves to RUN with no tick.
  - RUN, periodic: each tap edge produces tick.
  - RUN, one-shot: the first tap edge produces tick and moves to DONE.
  - DONE: done = 1 and tick = 0 until the next write to this channel.
- A write with en = 0 to any state moves to IDLE. done is cleared.
- A write with en = 1 to a channel in ARM, RUN or DONE re-latches tap and mode and restarts in ARM.
- Simultaneous write and tap edge on the same channel: the write wins and no tick is produced that cycle.
- Channels are independent. Any number may tick in the same cycle.

## Timing
- Reset (rst = 0), asynchronously:
  - cnt = 0, tick = 0, done = 0, cfg_ready = 1, cfg_err = 0.
  - All channels go to IDLE; taps and modes reset to 0.
- Reset mid-operation aborts all channels. There is no pending state after release.
- Write latency: the write is accepted at edge E, and the channel is in its new state from E onward.
- Tick latency: tick is registered. If cnt[k] first reads 1 in cycle T, tick is high in cycle T+1 only.
- cfg_err is high in the cycle after the accept.
- done rises in the same cycle as the final one-shot tick.
- Counter wrap: bit CNT_W-1 falls at the wrap. That is not an edge, so no spurious tick.

## Configuration
- Macro CLKDIV_CTRL_TICKCNT_EN.
- Defined: adds output tick_cnt, NUM_CH*8 bits. It holds a per-channel saturating 8-bit count of ticks since the last write to that channel. The count clears on write and on reset, and sticks at 255.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package clkdiv_ctrl_pkg contains:
  - the channel state encoding: IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3;
  - the mode constants MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1;
  - the default widths.
- One sub-module, clkdiv_ctrl_ch: per-channel FSM, tap mux, edge detect and optional tick counter. It is instantiated NUM_CH times.
- The shared counter and the config handshake live in the top level.

## Test plan
- Reset: hold rst = 0 for 3 cycles with cfg_valid = 1 -> cnt = 0, tick = 0, done = 0, cfg_ready = 1, no accept.
- Periodic tap 0: write ch0 tap = 0, mode = 0, en = 1 -> after one discarded edge, tick[0] is high every 2nd cycle, 1 cycle wide. Over 20 cycles, ticks are exactly 2 cycles apart.
- One-shot tap 3: write ch1 tap = 3, mode = 1 -> exactly one tick[1] within 16 to 32 cycles. done[1] rises in the same cycle and stays 1 for 100 cycles. A rewrite with en = 0 clears done[1].
- Handshake and error: hold cfg_valid for 4 cycles -> cfg_ready pattern is 1, 0, 1, 0. A write with cfg_ch = 5 (NUM_CH = 4) -> cfg_err pulses once and no channel changes.
- Collision: rewrite ch0 in the exact cycle its tap edge occurs -> no tick that cycle, and ch0 re-enters ARM.
- Mid-run reset: assert rst while ch0 and ch2 are in RUN -> ticks stop at once. After release, no ticks until the channels are rewritten.

Source files
------------

// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and default widths for the clkdiv_ctrl tick scheduler.
package clkdiv_ctrl_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 32;
  localparam int TAP_W      = 5;
  localparam int CH_W       = 3;
  localparam int TCNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/clkdiv_ctrl_ch.sv
// One tick channel: tap mux, rising-edge detect, ARM/RUN/DONE sequencing.
// Optional saturating tick counter under CLKDIV_CTRL_TICKCNT_EN.
module clkdiv_ctrl_ch
  import clkdiv_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [TAP_W-1:0]  wr_tap,
  input  logic              wr_mode,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  cnt_prev,
  output logic              tick,
  output logic              done
`ifdef CLKDIV_CTRL_TICKCNT_EN
  ,
  output logic [TCNT_W-1:0] tick_cnt
`endif
);

  ch_state_e        state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             tap_edge;

  // Previous-bit comes from a whole-counter delay, so a tap change never sees a stale bit.
  assign tap_edge = cnt[tap_q] & ~cnt_prev[tap_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    if (wr) begin
      if (wr_en) begin
        tap_d   = wr_tap;
        mode_d  = wr_mode;
        state_d = ARM;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ARM:  if (tap_edge) state_d = RUN;
        RUN: begin
          if (tap_edge) begin
            tick_d = 1'b1;
            if (mode_q == MODE_ONESHOT) state_d = DONE;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign tick = tick_q;
  assign done = (state_q == DONE);

`ifdef CLKDIV_CTRL_TICKCNT_EN
  logic [TCNT_W-1:0] tcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else if (wr) begin
      tcnt_q <= '0;
    end else if (tick_d && (tcnt_q != '1)) begin
      tcnt_q <= tcnt_q + TCNT_W'(1);
    end
  end

  assign tick_cnt = tcnt_q;
`endif

endmodule

// File: rtl/clkdiv_ctrl.sv
// Multi-channel tick scheduler on a shared free-running divider counter.
// Define CLKDIV_CTRL_TICKCNT_EN to add the per-channel tick_cnt output.
module clkdiv_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [TAP_W-1:0]         cfg_tap,
  input  logic                     cfg_mode,
  input  logic                     cfg_en,
  output logic                     cfg_err,
  output logic [NUM_CH-1:0]        tick,
  output logic [NUM_CH-1:0]        done,
  output logic [CNT_W-1:0]         cnt
`ifdef CLKDIV_CTRL_TICKCNT_EN
  ,
  output logic [NUM_CH*TCNT_W-1:0] tick_cnt
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_prev_q;
  logic             busy_q;
  logic             err_q;
  logic             accept;

  assign accept    = cfg_valid && !busy_q;
  assign cfg_ready = !busy_q;
  assign cfg_err   = err_q;
  assign cnt       = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      cnt_prev_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_q + CNT_W'(1);
      cnt_prev_q <= cnt_q;
      busy_q     <= accept;
      err_q      <= accept && (int'(cfg_ch) >= NUM_CH);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = accept && (int'(cfg_ch) == i);

    clkdiv_ctrl_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .wr_tap   (cfg_tap),
      .wr_mode  (cfg_mode),
      .wr_en    (cfg_en),
      .cnt      (cnt_q),
      .cnt_prev (cnt_prev_q),
      .tick     (tick[i]),
      .done     (done[i])
`ifdef CLKDIV_CTRL_TICKCNT_EN
      ,
      .tick_cnt (tick_cnt[i*TCNT_W +: TCNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl against an edge-counting reference model.
module tb_clkdiv_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = '0;
  logic [4:0]        cfg_tap = '0;
  logic              cfg_mode = 1'b0;
  logic              cfg_en = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] done;
  logic [CNT_W-1:0]  cnt;
`ifdef CLKDIV_CTRL_TICKCNT_EN
  logic [NUM_CH*8-1:0] tick_cnt;
`endif

  clkdiv_ctrl #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_tap   (cfg_tap),
    .cfg_mode  (cfg_mode),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .done      (done),
    .cnt       (cnt)
`ifdef CLKDIV_CTRL_TICKCNT_EN
    ,
    .tick_cnt  (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts tap rising edges seen since the last write.
  bit [31:0] m_cnt;
  bit        m_ready;
  bit        m_err;
  bit        m_act  [NUM_CH];
  int        m_tap  [NUM_CH];
  bit        m_mode [NUM_CH];
  int        m_n    [NUM_CH];
  bit        m_tick [NUM_CH];
  bit        m_done [NUM_CH];
  int        m_tcnt [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tap_rises(input int tap, input bit [31:0] c);
    longint unsigned period;
    period = longint'(1) << (tap + 1);
    return (longint'(c) % period) == (longint'(1) << tap);
  endfunction

  task automatic model_reset();
    m_cnt   = '0;
    m_ready = 1'b1;
    m_err   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_tap[c] = 0; m_mode[c] = 0; m_n[c] = 0;
      m_tick[c] = 0; m_done[c] = 0; m_tcnt[c] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = cfg_valid && m_ready;
    for (int c = 0; c < NUM_CH; c++) begin
      m_tick[c] = 0;
      if (acc && int'(cfg_ch) == c) begin
        m_act[c] = cfg_en; m_tap[c] = int'(cfg_tap); m_mode[c] = cfg_mode;
        m_n[c] = 0; m_done[c] = 0; m_tcnt[c] = 0;
      end else if (m_act[c] && tap_rises(m_tap[c], m_cnt)) begin
        if (m_n[c] < 3) m_n[c]++;
        // first edge discarded; periodic ticks on every later edge, one-shot only on the second
        if (m_n[c] >= 2 && (!m_mode[c] || m_n[c] == 2) && !m_done[c]) begin
          m_tick[c] = 1;
          if (m_tcnt[c] < 255) m_tcnt[c]++;
          if (m_mode[c]) m_done[c] = 1;
        end
      end
    end
    m_err   = acc && (int'(cfg_ch) >= NUM_CH);
    m_ready = !acc;
    m_cnt   = m_cnt + 1;
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] et, ed;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = m_tick[c];
      ed[c] = m_done[c];
    end
    chk("cnt", 64'(cnt), 64'(m_cnt));
    chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
    chk("tick", 64'(tick), 64'(et));
    chk("done", 64'(done), 64'(ed));
`ifdef CLKDIV_CTRL_TICKCNT_EN
    for (int c = 0; c < NUM_CH; c++)
      chk("tick_cnt", 64'(tick_cnt[c*8 +: 8]), 64'(m_tcnt[c]));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic write(input int ch, input int tap, input bit mode, input bit en);
    if (!m_ready) cycle();
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_tap   = 5'(tap);
    cfg_mode  = mode;
    cfg_en    = en;
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int last_t, gap, nticks, errs, found;
    int rdy_seen[4];
    int rdy_exp[4];

    rdy_exp = '{1, 0, 1, 0};
    model_reset();

    // Reset held with cfg_valid asserted: nothing may be accepted.
    rst = 1'b0;
    cfg_valid = 1'b1;
    cfg_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (4) cycle();

    // Periodic on tap 0: consecutive ticks exactly two cycles apart.
    write(0, 0, 1'b0, 1'b1);
    last_t = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (tick[0]) begin
        if (last_t >= 0) begin
          gap = k - last_t;
          chk("tick_spacing", 64'(gap), 64'd2);
        end
        last_t = k;
      end
    end

    // One-shot on tap 3.
    write(1, 3, 1'b1, 1'b1);
    nticks = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (tick[1]) nticks++;
    end
    chk("oneshot_ticks", 64'(nticks), 64'd1);
    repeat (100) cycle();
    chk("oneshot_done_held", 64'(done[1]), 64'd1);
    write(1, 3, 1'b1, 1'b0);
    chk("done_cleared", 64'(done[1]), 64'd0);

    // Held cfg_valid: ready alternates.
    cycle();
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_tap = 5'd2; cfg_mode = 1'b0; cfg_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdy_seen[k] = int'(cfg_ready);
      cycle();
    end
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) chk("ready_pattern", 64'(rdy_seen[k]), 64'(rdy_exp[k]));

    // Out-of-range channel: one error pulse, no channel affected.
    cycle();
    write(5, 1, 1'b0, 1'b1);
    errs = int'(cfg_err);
    repeat (3) begin
      cycle();
      errs += int'(cfg_err);
    end
    chk("err_pulses", 64'(errs), 64'd1);

    // Collision: rewrite ch0 (tap 1, RUN) in the cycle its tap rises.
    write(0, 1, 1'b0, 1'b1);
    repeat (12) cycle();
    found = 0;
    for (int k = 0; k < 64 && found == 0; k++) begin
      if (tap_rises(1, m_cnt) && m_ready) found = 1;
      else cycle();
    end
    chk("collision_found", 64'(found), 64'd1);
    write(0, 1, 1'b0, 1'b1);
    chk("collision_tick", 64'(tick[0]), 64'd0);
    repeat (8) cycle();

    // Mid-run reset with ch0 and ch2 running.
    write(2, 0, 1'b0, 1'b1);
    repeat (20) cycle();
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_tick", 64'(tick), 64'd0);
    chk("async_rst_cnt", 64'(cnt), 64'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b1;
    nticks = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (tick != '0) nticks++;
    end
    chk("post_reset_ticks", 64'(nticks), 64'd0);

    // Randomized traffic, including out-of-range channels.
    for (int k = 0; k < 400; k++) begin
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_ch    = 3'($urandom_range(0, 5));
      cfg_tap   = 5'($urandom_range(0, 4));
      cfg_mode  = 1'($urandom_range(0, 1));
      cfg_en    = ($urandom_range(0, 9) < 8);
      cycle();
    end
    cfg_valid = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
